play_ctrl: RTL and testbench

PLAY_CTRL -- requirements
Module: play_ctrl

---
 rtl/play_pkg.sv | 32 +++
 rtl/key_debounce.sv | 47 ++++
 rtl/play_ctrl.sv | 71 +++++++
 tb/tb_play_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/play_pkg.sv
// Shared types and constants for the playback control block.
package play_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int unsigned SLICE_MAX = 16;
    localparam int unsigned SLICE_W   = 5;

    localparam int unsigned KEY_START = 0;
    localparam int unsigned KEY_PAUSE = 1;
    localparam int unsigned KEY_UP    = 2;
    localparam int unsigned KEY_DOWN  = 3;

    // Saturating slice step; simultaneous up and down cancel out.
    function automatic logic [SLICE_W-1:0] slice_step(input logic [SLICE_W-1:0] cur,
                                                      input logic up,
                                                      input logic down);
        logic [SLICE_W-1:0] nxt;
        nxt = cur;
        if (up && !down && (cur < SLICE_W'(SLICE_MAX))) begin
            nxt = cur + SLICE_W'(1);
        end else if (down && !up && (cur != '0)) begin
            nxt = cur - SLICE_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: two-flop synchronizer, counter debounce, registered press pulse.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic            level_prev_q;
    logic            press_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= key_n_i;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            // Only the falling (pressed) edge of the debounced level is an event.
            press_q      <= level_prev_q & ~level_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/play_ctrl.sv
// Playback control: debounced keys drive a start/pause FSM and a slice selector.
module play_ctrl
    import play_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         key_n_i,
    input  logic               done_i,
    output logic               start_o,
    output logic               pause_o,
    output logic [1:0]         state_o,
    output logic [SLICE_W-1:0] slice_num_o
);

    logic [3:0]         press;
    state_t             state_q;
    logic               start_q;
    logic               pause_q;
    logic [SLICE_W-1:0] slice_q;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk    (clk),
            .rst_n  (rst_n),
            .key_n_i(key_n_i[i]),
            .press_o(press[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            pause_q <= 1'b0;
            slice_q <= '0;
        end else begin
            start_q <= 1'b0;
            pause_q <= 1'b0;
            case (state_q)
                IDLE, PAUSE: begin
                    slice_q <= slice_step(slice_q, press[KEY_UP], press[KEY_DOWN]);
                    // A coincident pause press suppresses start outside PLAY.
                    if (press[KEY_START] && !press[KEY_PAUSE]) begin
                        state_q <= PLAY;
                        start_q <= 1'b1;
                    end
                end
                PLAY: begin
                    if (done_i) begin
                        state_q <= IDLE;
                        pause_q <= 1'b1;
                    end else if (press[KEY_PAUSE]) begin
                        state_q <= PAUSE;
                        pause_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_o     = start_q;
    assign pause_o     = pause_q;
    assign state_o     = state_q;
    assign slice_num_o = slice_q;

endmodule

// File: tb/tb_play_ctrl.sv
// Directed bench for play_ctrl with a short debounce window.
module tb_play_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_n;
    logic       done;
    logic       start_o;
    logic       pause_o;
    logic [1:0] state_o;
    logic [4:0] slice_num_o;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;
    int pause_cnt = 0;
    int both_cnt  = 0;

    play_ctrl #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n_i    (key_n),
        .done_i     (done),
        .start_o    (start_o),
        .pause_o    (pause_o),
        .state_o    (state_o),
        .slice_num_o(slice_num_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_o) start_cnt++;
        if (pause_o) pause_cnt++;
        if (start_o && pause_o) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] mask, input int n);
        @(negedge clk);
        key_n = ~mask;
        repeat (n) @(negedge clk);
        key_n = 4'hF;
        idle(12);
    endtask

    int first;
    int pulses;
    int st6;
    int s0;
    int p0;

    initial begin
        rst_n = 1'b0;
        key_n = 4'hF;
        done  = 1'b0;
        idle(3);
        check("rst_state", 32'(state_o), 0);
        check("rst_slice", 32'(slice_num_o), 0);
        check("rst_start", 32'(start_o), 0);
        check("rst_pause", 32'(pause_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // Start press latency: pulse seven edges after the first sampling edge.
        @(negedge clk);
        key_n[0] = 1'b0;
        first  = -1;
        pulses = 0;
        st6    = -1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (start_o) begin
                pulses++;
                if (first < 0) first = k;
            end
            if (k == 6) st6 = 32'(state_o);
        end
        key_n = 4'hF;
        idle(12);
        check("start_latency", 32'(first), 7);
        check("start_pulses", 32'(pulses), 1);
        check("state_before_start", 32'(st6), 0);
        check("state_play", 32'(state_o), 1);

        // Short glitch on pause: ignored.
        p0 = pause_cnt;
        @(negedge clk);
        key_n[1] = 1'b0;
        repeat (3) @(negedge clk);
        key_n = 4'hF;
        idle(15);
        check("glitch_no_pause", 32'(pause_cnt - p0), 0);
        check("glitch_state", 32'(state_o), 1);

        press(4'b0100, 6);
        check("play_up_ignored", 32'(slice_num_o), 0);

        // done_i coinciding with a pause press.
        p0 = pause_cnt;
        @(negedge clk);
        key_n[1] = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        key_n = 4'hF;
        idle(12);
        check("done_pause_pulses", 32'(pause_cnt - p0), 1);
        check("done_state_idle", 32'(state_o), 0);

        // Slice saturation in IDLE.
        s0 = start_cnt;
        for (int i = 0; i < 3; i++) press(4'b0100, 6);
        check("slice_up3", 32'(slice_num_o), 3);
        for (int i = 0; i < 17; i++) press(4'b0100, 6);
        check("slice_sat_hi", 32'(slice_num_o), 16);
        for (int i = 0; i < 20; i++) press(4'b1000, 6);
        check("slice_sat_lo", 32'(slice_num_o), 0);
        press(4'b0100, 6);
        check("slice_up1", 32'(slice_num_o), 1);
        press(4'b1100, 6);
        check("slice_both", 32'(slice_num_o), 1);
        check("slice_no_start", 32'(start_cnt - s0), 0);

        // PAUSE with simultaneous start+pause, then start alone.
        press(4'b0001, 6);
        check("resume_play", 32'(state_o), 1);
        press(4'b0010, 6);
        check("to_pause", 32'(state_o), 2);
        s0 = start_cnt;
        p0 = pause_cnt;
        press(4'b0011, 6);
        check("both_state", 32'(state_o), 2);
        check("both_no_start", 32'(start_cnt - s0), 0);
        check("both_no_pause", 32'(pause_cnt - p0), 0);
        press(4'b0001, 6);
        check("pause_resume_state", 32'(state_o), 1);
        check("pause_resume_start", 32'(start_cnt - s0), 1);

        // Reset mid-PLAY with slice 9.
        press(4'b0010, 6);
        for (int i = 0; i < 8; i++) press(4'b0100, 6);
        press(4'b0001, 6);
        check("pre_rst_state", 32'(state_o), 1);
        check("pre_rst_slice", 32'(slice_num_o), 9);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state_o), 0);
        check("async_rst_slice", 32'(slice_num_o), 0);
        idle(2);
        s0 = start_cnt;
        p0 = pause_cnt;
        rst_n = 1'b1;
        idle(15);
        check("post_rst_no_start", 32'(start_cnt - s0), 0);
        check("post_rst_no_pause", 32'(pause_cnt - p0), 0);
        check("post_rst_state", 32'(state_o), 0);

        // Key held through a reset, pending debounce discarded.
        @(negedge clk);
        key_n[0] = 1'b0;
        idle(3);
        rst_n = 1'b0;
        idle(3);
        s0 = start_cnt;
        rst_n = 1'b1;
        idle(3);
        check("held_early_state", 32'(state_o), 0);
        idle(12);
        check("held_late_state", 32'(state_o), 1);
        check("held_one_start", 32'(start_cnt - s0), 1);
        key_n = 4'hF;
        idle(12);

        check("never_both", 32'(both_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
